// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the argon core: owns PC/IR, runs the
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK walk and the imem/dmem request handshakes.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_instruction,
    input  logic        i_is_reg_write,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic        i_is_jump,
    input  logic        i_is_branch,
    input  logic [31:0] i_jump_address,
    input  logic        i_branch_taken,
    input  logic [31:0] i_mem_addr,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    input  logic        i_dmem_ack,
    output logic        o_rf_we,
    output logic        o_retire,
    output logic [31:0] o_retired_count,
    output logic        o_halted,
    output logic [2:0]  o_state
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM       = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    logic [2:0]  state, state_nxt;
    logic [31:0] pc, ir, retired_count;
    logic [31:0] next_pc;
    logic        take_jump, misaligned;
    logic        in_fetch, in_mem, in_wb;

    assign in_fetch = (state == S_FETCH);
    assign in_mem   = (state == S_MEM);
    assign in_wb    = (state == S_WRITEBACK);

    assign take_jump  = i_is_jump | (i_is_branch & i_branch_taken);
    assign next_pc    = take_jump ? i_jump_address : pc + 32'd4;
    assign misaligned = |next_pc[1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:     if (i_imem_ack) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = S_EXECUTE;
            S_EXECUTE:   state_nxt = (i_is_load | i_is_store) ? S_MEM : S_WRITEBACK;
            S_MEM:       if (i_dmem_ack) state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = misaligned ? S_HALT : S_FETCH;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_FETCH;
        else         state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ir <= NOP_INSN;
        end else if (in_fetch && i_imem_ack) begin
            ir <= i_imem_rdata;
        end
    end

    // A trapping writeback leaves PC and the counter untouched.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc            <= RESET_PC;
            retired_count <= 32'd0;
        end else if (in_wb && !misaligned) begin
            pc            <= next_pc;
            retired_count <= retired_count + 32'd1;
        end
    end

    assign o_imem_req      = !i_reset && in_fetch;
    assign o_imem_addr     = pc;
    assign o_pc            = pc;
    assign o_instruction   = ir;
    assign o_dmem_req      = !i_reset && in_mem;
    assign o_dmem_we       = !i_reset && in_mem && i_is_store;
    assign o_dmem_addr     = i_mem_addr;
    assign o_rf_we         = !i_reset && in_wb && i_is_reg_write;
    assign o_retire        = !i_reset && in_wb && !misaligned;
    assign o_retired_count = retired_count;
    assign o_halted        = (state == S_HALT);
    assign o_state         = state;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the argon core. It owns the PC and instruction register, drives the instruction-memory and data-memory request handshakes, and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It sits beside `instruction_decode`: it feeds that block `i_pc` and `i_instruction` and consumes its load, store, jump, branch and reg-write flags. It produces the register-file write strobe and retire events.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSN`, default 32'h0000_0013: IR value on reset (`addi x0,x0,0`).
- `i_clk` in 1: the single clock; all state updates on its rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `o_imem_req` in/out: out 1: instruction fetch request.
- `o_imem_addr` out 32: fetch address; equals `o_pc`.
- `i_imem_ack` in 1: fetch complete; `i_imem_rdata` is valid this cycle.
- `i_imem_rdata` in 32: fetched instruction.
- `o_pc` out 32: PC of the instruction held in the IR; feeds decode `i_pc`.
- `o_instruction` out 32: IR; feeds decode `i_instruction`.
- `i_is_reg_write` in 1: decode flag.
- `i_is_load` in 1: decode flag.
- `i_is_store` in 1: decode flag.
- `i_is_jump` in 1: decode flag.
- `i_is_branch` in 1: decode flag.
- `i_jump_address` in 32: target for jumps and taken branches.
- `i_branch_taken` in 1: branch compare result from the ALU; valid in EXECUTE and WRITEBACK.
- `i_mem_addr` in 32: ALU result, used as the data address.
- `o_dmem_req` out 1: data request.
- `o_dmem_we` out 1: 1 = store, 0 = load.
- `o_dmem_addr` out 32: data address.
- `i_dmem_ack` in 1: data transfer complete.
- `o_rf_we` out 1: register-file write strobe, one cycle.
- `o_retire` out 1: one-cycle pulse per completed instruction.
- `o_retired_count` out 32: retired-instruction counter.
- `o_halted` out 1: set by a misaligned-PC trap.
- `o_state` out 3: current state, for debug.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5. Any other value goes to HALT.
- **FETCH**
  - `o_imem_req`=1 and `o_imem_addr`=PC.
  - On `i_imem_ack`: IR <= `i_imem_rdata`, go to DECODE.
  - Otherwise hold FETCH with the request held high.
- **DECODE:** one cycle for decode and register-file read to settle; go to EXECUTE.
- **EXECUTE:** one cycle.
  - Go to MEM if `i_is_load` or `i_is_store`.
  - Otherwise go to WRITEBACK.
- **MEM**
  - `o_dmem_req`=1, `o_dmem_we`=`i_is_store`, `o_dmem_addr`=`i_mem_addr`.
  - Hold MEM until `i_dmem_ack`, then go to WRITEBACK.
- **WRITEBACK:** one cycle.
  - `o_rf_we`=`i_is_reg_write`. The x0 filter lives in the register file.
  - Next PC = `i_jump_address` if `i_is_jump` or (`i_is_branch` and `i_branch_taken`); otherwise PC+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
  - If next PC[1:0] != 0: go to HALT and leave PC unchanged.
  - Otherwise: PC <= next PC, pulse `o_retire`, increment `o_retired_count` (wraps at 2^32), go to FETCH.
- **HALT:** `o_halted`=1 and all requests 0. Only reset exits HALT.
- **Acks outside their wait state:** `i_imem_ack` outside FETCH and `i_dmem_ack` outside MEM are ignored.
- **Trapped instruction:** the instruction that trapped does not retire and does not increment the counter. Its `o_rf_we` still asserts in that WRITEBACK cycle (link write occurs).
- **Decode inputs:** sampled combinationally while in EXECUTE, MEM and WRITEBACK. The IR is stable across these states.

## Timing
- **Reset values:** state=FETCH, `o_pc`=`RESET_PC`, `o_instruction`=`NOP_INSN`, `o_retired_count`=0, `o_halted`=0.
- **Reset gating:** `o_imem_req`, `o_dmem_req`, `o_dmem_we`, `o_rf_we` and `o_retire` are forced to 0 while `i_reset`=1. `o_imem_req` rises in the first cycle after reset deasserts.
- **Request outputs:** Moore decodes of state, gated only by reset. The request stays high until the ack cycle inclusive, and drops in the cycle after the ack.
- **Same-cycle ack:** an ack in the same cycle as the request is legal.
- **Latency with zero-wait memories:**
  - ALU, jump or branch: 4 cycles from FETCH entry to the next FETCH entry.
  - Load or store: 5 cycles.
- **Wait states:** each memory wait state adds exactly one cycle.
- **Reset mid-operation:** asynchronous return to reset values. Any pending request is abandoned, with no retire and no `o_rf_we`. Memories share `i_reset` and must drop in-flight acks.
- **Retire timing:** `o_retire` and `o_rf_we` coincide in the WRITEBACK cycle. `o_pc` and `o_retired_count` update on the clock edge ending that cycle.

## Test plan
- **Reset then ADDI:** release reset with `0x00500193` and ack on the first FETCH cycle. Require:
  - FETCH, DECODE, EXECUTE, WRITEBACK in consecutive cycles.
  - `o_rf_we`=1 in cycle 4.
  - `o_pc`=0x4, count=1.
- **LW with 2 wait cycles:** `i_is_load`=1, `i_mem_addr`=0x104, `i_dmem_ack` on the 3rd MEM cycle. Require:
  - `o_dmem_req` high for 3 cycles, `o_dmem_we`=0, addr 0x104.
  - Total 7 cycles, `o_rf_we`=1.
- **SW, zero wait:** `i_is_store`=1, `i_is_reg_write`=0, PC=0xC. Require:
  - `o_dmem_we`=1 for exactly one cycle.
  - `o_rf_we`=0, `o_pc`=0x10.
- **Branches:**
  - BEQ with `i_branch_taken`=1 and target 0x40 at PC=0x10: next `o_pc`=0x40.
  - Same BEQ with `i_branch_taken`=0: next `o_pc`=0x14.
- **JALR to misaligned target:** `i_jump_address`=0x1A. Require:
  - HALT with `o_halted`=1, `o_pc` unchanged, count unchanged.
  - Requests stay 0 for 10 cycles.
  - Only reset recovers, with `o_pc`=`RESET_PC`.
- **Reset mid-MEM and stray acks:**
  - Assert `i_reset` during MEM with no ack: outputs return to reset values asynchronously, no `o_retire`.
  - Drive `i_dmem_ack` during FETCH: ignored.
